// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer, mid-bit sampling and a
// single-entry holding register with valid/ready handshake and sticky overrun.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitM1  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic            deliver;
    logic            accept;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Every sample point lands where the phase counter wraps, so T0-relative
    // timing is set entirely by the START half-bit and the full-bit periods.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        if (!ena) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfM1) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_s ? StIdle : StData;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StData: begin
                    if (cnt_q == BitM1) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = StStop;
                        end
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StStop: begin
                    if (cnt_q == BitM1) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                        if (rx_s) begin
                            deliver = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign accept = valid_q & rx_ready;

    // A delivery only displaces the held byte when that byte leaves on the same edge.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (deliver) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written sequences for
// glitch rejection, back-to-back frames, enable gating, overrun and mid-frame reset.
module tb_uart_rx;

    localparam int unsigned Cpb = 16;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters are owned by the monitor; the stimulus only reads deltas.
    int         valid_cyc;
    int         ferr_cyc;
    int         busy_cyc;
    logic [7:0] acc_q[$];

    initial begin
        valid_cyc = 0;
        ferr_cyc  = 0;
        busy_cyc  = 0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) valid_cyc++;
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
            if (frame_err) ferr_cyc++;
            if (busy) busy_cyc++;
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (Cpb) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    int         v0, f0, b0, a0;
    logic [7:0] dq;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_valid: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_data: 8'hA5, exp_valid: 0, exp_ferr: 1};
        vecs[2] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_valid: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'hFF, stop: 1'b0, exp_data: 8'h00, exp_valid: 0, exp_ferr: 1};
        vecs[4] = '{data: 8'h5A, stop: 1'b1, exp_data: 8'h5A, exp_valid: 1, exp_ferr: 0};
        vecs[5] = '{data: 8'h81, stop: 1'b1, exp_data: 8'h81, exp_valid: 1, exp_ferr: 0};

        rst_n    = 1'b0;
        ena      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        check("reset rx_data", 32'(rx_data), 32'h00);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        foreach (vecs[k]) begin
            v0 = valid_cyc;
            f0 = ferr_cyc;
            send_frame(vecs[k].data, vecs[k].stop);
            idle(20);
            check($sformatf("vec%0d valid cycles", k), 32'(valid_cyc - v0), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d frame_err cycles", k), 32'(ferr_cyc - f0), 32'(vecs[k].exp_ferr));
            check($sformatf("vec%0d rx_data", k), 32'(rx_data), 32'(vecs[k].exp_data));
            check($sformatf("vec%0d overrun", k), 32'(overrun), 32'd0);
            check($sformatf("vec%0d busy", k), 32'(busy), 32'd0);
        end

        // Short low pulse: start-bit check rejects it after half a bit.
        v0 = valid_cyc;
        f0 = ferr_cyc;
        b0 = busy_cyc;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(30);
        check("glitch busy bounded", 32'((busy_cyc - b0) >= 1 && (busy_cyc - b0) <= 8), 32'd1);
        check("glitch no valid", 32'(valid_cyc - v0), 32'd0);
        check("glitch no frame_err", 32'(ferr_cyc - f0), 32'd0);

        // Back-to-back frames with no idle gap.
        a0 = acc_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("b2b deliveries", 32'(acc_q.size() - a0), 32'd2);
        dq = (acc_q.size() > a0) ? acc_q[a0] : 8'hEE;
        check("b2b first byte", 32'(dq), 32'h00);
        dq = (acc_q.size() > a0 + 1) ? acc_q[a0 + 1] : 8'hEE;
        check("b2b second byte", 32'(dq), 32'hFF);

        // Disabled receiver ignores a whole frame.
        ena = 1'b0;
        v0  = valid_cyc;
        b0  = busy_cyc;
        send_frame(8'h00, 1'b1);
        idle(20);
        check("ena0 busy cycles", 32'(busy_cyc - b0), 32'd0);
        check("ena0 valid cycles", 32'(valid_cyc - v0), 32'd0);
        ena = 1'b1;
        idle(5);

        // Overrun: second byte lost while first is held.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(5);
        check("ovr first valid", 32'(rx_valid), 32'd1);
        check("ovr first data", 32'(rx_data), 32'h11);
        check("ovr not yet", 32'(overrun), 32'd0);
        send_frame(8'h22, 1'b1);
        idle(5);
        check("ovr data held", 32'(rx_data), 32'h11);
        check("ovr set", 32'(overrun), 32'd1);
        check("ovr valid held", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        idle(2);
        check("ovr accept valid", 32'(rx_valid), 32'd0);
        check("ovr sticky", 32'(overrun), 32'd1);
        rx_ready = 1'b1;

        // Reset during data bit 3, then a clean frame.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        repeat (Cpb / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst rx_data", 32'(rx_data), 32'h00);
        check("midrst rx_valid", 32'(rx_valid), 32'd0);
        check("midrst frame_err", 32'(frame_err), 32'd0);
        check("midrst overrun", 32'(overrun), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        v0 = valid_cyc;
        f0 = ferr_cyc;
        a0 = acc_q.size();
        send_frame(8'h5A, 1'b1);
        idle(20);
        check("postrst valid cycles", 32'(valid_cyc - v0), 32'd1);
        check("postrst frame_err", 32'(ferr_cyc - f0), 32'd0);
        dq = (acc_q.size() > a0) ? acc_q[a0] : 8'hEE;
        check("postrst byte", 32'(dq), 32'h5A);
        check("postrst rx_data", 32'(rx_data), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
